// File: rtl/lookup3_pkg.sv
// Shared types, constants and helpers for the lookup3 (hashlittle) sequencer.
// Optional build macro used by the top: LOOKUP3_BSWAP_EN.
package lookup3_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MIX, FINAL, DONE} state_t;
  typedef enum logic {RND_MIX, RND_FINAL} rnd_mode_t;

  localparam logic [31:0] GOLDEN = 32'hDEADBEEF;

  localparam int MIX_ROT [6] = '{4, 6, 8, 16, 19, 4};
  localparam int FIN_ROT [7] = '{14, 11, 25, 16, 4, 14, 24};

  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Keeps the low (rem mod 4) bytes of the last tail word; 0 means a full word.
  function automatic logic [31:0] tail_mask(input logic [1:0] r);
    case (r)
      2'd1:    return 32'h0000_00FF;
      2'd2:    return 32'h0000_FFFF;
      2'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/lookup3_round.sv
// Combinational lookup3 round: either the 6-step mix or the 7-step final,
// shared by the MIX and FINAL states of the sequencer.
module lookup3_round
  import lookup3_pkg::*;
(
  input  rnd_mode_t   mode,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out
);

  logic [31:0] x, y, z;

  always_comb begin
    x = a_in;
    y = b_in;
    z = c_in;
    if (mode == RND_MIX) begin
      x = x - z;  x = x ^ rot(z, MIX_ROT[0]);  z = z + y;
      y = y - x;  y = y ^ rot(x, MIX_ROT[1]);  x = x + z;
      z = z - y;  z = z ^ rot(y, MIX_ROT[2]);  y = y + x;
      x = x - z;  x = x ^ rot(z, MIX_ROT[3]);  z = z + y;
      y = y - x;  y = y ^ rot(x, MIX_ROT[4]);  x = x + z;
      z = z - y;  z = z ^ rot(y, MIX_ROT[5]);  y = y + x;
    end else begin
      z = z ^ y;  z = z - rot(y, FIN_ROT[0]);
      x = x ^ z;  x = x - rot(z, FIN_ROT[1]);
      y = y ^ x;  y = y - rot(x, FIN_ROT[2]);
      z = z ^ y;  z = z - rot(y, FIN_ROT[3]);
      x = x ^ z;  x = x - rot(z, FIN_ROT[4]);
      y = y ^ x;  y = y - rot(x, FIN_ROT[5]);
      z = z ^ y;  z = z - rot(y, FIN_ROT[6]);
    end
  end

  assign a_out = x;
  assign b_out = y;
  assign c_out = z;

endmodule

// File: rtl/lookup3_seq.sv
// lookup3 (hashlittle) sequencer: consumes a little-endian word stream, emits c.
// Define LOOKUP3_BSWAP_EN to accept big-endian packed key words instead.
module lookup3_seq
  import lookup3_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      initval,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash,
  output logic             busy
);

  state_t           state, state_nx;
  logic [31:0]      a, b, c;
  logic [LEN_W-1:0] rem;
  logic [1:0]       w;

  logic [31:0] seed, word, kword;
  logic [31:0] ra, rb, rc;
  logic [3:0]  r4;
  logic [1:0]  need;
  logic        full_blk, last_word, xfer;

  assign seed = GOLDEN + 32'(len) + initval;

`ifdef LOOKUP3_BSWAP_EN
  assign word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word = in_data;
`endif

  // A block holds 3 words unless it is the tail, which holds ceil(rem/4).
  assign full_blk  = rem > LEN_W'(12);
  assign r4        = rem[3:0] + 4'd3;
  assign need      = full_blk ? 2'd3 : r4[3:2];
  assign last_word = (w == need - 2'd1);
  assign kword     = word & ((!full_blk && last_word) ? tail_mask(rem[1:0]) : 32'hFFFF_FFFF);
  assign xfer      = in_valid & in_ready;

  lookup3_round u_round (
    .mode  (state == FINAL ? RND_FINAL : RND_MIX),
    .a_in  (a),
    .b_in  (b),
    .c_in  (c),
    .a_out (ra),
    .b_out (rb),
    .c_out (rc)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nx = (len == '0) ? DONE : LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nx = full_blk ? MIX : FINAL;
      end
      MIX:   state_nx = LOAD;
      FINAL: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Words are accumulated into a/b/c as they arrive; unused tail words add 0.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      rem      <= '0;
      w        <= '0;
      out_hash <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a   <= seed;
          b   <= seed;
          c   <= seed;
          rem <= len;
          w   <= '0;
          if (len == '0) out_hash <= seed;
        end
        LOAD: if (xfer) begin
          case (w)
            2'd0:    a <= a + kword;
            2'd1:    b <= b + kword;
            default: c <= c + kword;
          endcase
          w <= last_word ? 2'd0 : w + 2'd1;
        end
        MIX: begin
          a   <= ra;
          b   <= rb;
          c   <= rc;
          rem <= rem - LEN_W'(12);
          w   <= '0;
        end
        FINAL: begin
          a        <= ra;
          b        <= rb;
          c        <= rc;
          out_hash <= rc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lookup3_seq.md
Name: lookup3_seq

Overview:
Sequencer for the lookup3 (hashlittle) hash datapath.
- Accepts a key length, a seed and a little-endian word stream.
- Steps the a/b/c state through one mix round per full 12-byte block, then masks the tail block and applies the final round.
- Presents the 32-bit hash c on a valid/ready output.
- Sits between a key-fetch unit (for example, a cache-item key reader) and consumers of the hash (bucket index logic).

Parameters:
- LEN_W, 32: width of the byte-length input and of the internal remaining-byte counter.

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  reset, asynchronous, active-high
- start  in  1  begin a new hash; sampled only in IDLE
- len  in  LEN_W  key length in bytes; sampled with start
- initval  in  32  seed; sampled with start
- in_valid  in  1  in_data holds a key word
- in_ready  out  1  sequencer accepts a word this cycle
- in_data  in  32  key word; byte 0 of the word is in [7:0]
- out_valid  out  1  out_hash is valid
- out_ready  in  1  consumer accepts out_hash
- out_hash  out  32  final c value
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, res=1): state=IDLE; in_ready=0, out_valid=0, busy=0, out_hash=0; a/b/c, word index and remaining counter cleared. Reset mid-hash abandons the hash; no output is produced.
- State machine: IDLE, LOAD, MIX, FINAL, DONE.
- IDLE, on start:
  - a=b=c=32'hDEADBEEF+len+initval, mod 2^32.
  - rem=len; word index w=0.
  - If len==0, go to DONE with out_hash=c. No words are consumed and no final round is applied.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready=1 while in LOAD. A transfer occurs when in_valid&in_ready.
  - Words go to k0,k1,k2 in order of w.
  - Words needed in the block: 3 if rem>12, else ceil(rem/4).
  - After the last needed word of a block:
    - If rem>12, add a+=k0, b+=k1, c+=k2 and go to MIX.
    - Otherwise, treat unused k words as 0 and mask the partial last word, keeping the low (rem mod 4) bytes: 1 keeps 32'h000000FF, 2 keeps 32'h0000FFFF, 3 keeps 32'h00FFFFFF, 0 keeps the full word. Then add and go to FINAL.
- MIX (1 cycle, in_ready=0):
  - Apply the standard lookup3 mix (6 subtract/xor/rotate steps) to a/b/c.
  - rem-=12, w=0, return to LOAD.
- FINAL (1 cycle):
  - Apply the standard final round: 7 steps, rotates 14,11,25,16,4,14,24.
  - Load out_hash=c and go to DONE.
- DONE:
  - out_valid=1. out_hash is held stable until out_valid&out_ready, then IDLE.
- Handshakes and corner cases:
  - start while busy is ignored.
  - in_data is ignored whenever in_ready=0.
  - out_valid never drops without a handshake.
- Latency for len>0: one MIX cycle per full block except the last, plus one FINAL cycle, plus one cycle into DONE. For len=12 and words presented back-to-back, out_valid rises 2 cycles after the 3rd word transfer.
- Arithmetic and widths:
  - All a/b/c arithmetic is 32-bit, wrap-around.
  - Rotates are true 32-bit rotates: (x<<k)|(x>>(32-k)).
  - len is zero-extended to 32 bits before the add.

Optional Feature:
- Macro LOOKUP3_BSWAP_EN.
- Defined: each accepted in_data is byte-swapped before masking, so keys packed big-endian (first byte in [31:24]) hash identically to the little-endian packing.
- Undefined: in_data is used as received, with no swap logic.

Decomposition:
- Package lookup3_pkg holds:
  - the state enum;
  - the constant 32'hDEADBEEF;
  - the rotate amounts for mix and final;
  - the tail mask function (rem mod 4 to mask).
- One sub-module, lookup3_round. It is combinational: inputs a/b/c and a mode select (mix or final), outputs new a/b/c. Instantiated once and shared by the MIX and FINAL states.

Test Plan:
- len=0, initval=0, start -> out_valid with out_hash=32'hDEADBEEF; no in_ready pulse.
- len=0, initval=32'hDEADBEEF -> out_hash=32'hBD5B7DDE.
- "Four score and seven years ago" (30 bytes, 8 words, little-endian), initval=0 -> out_hash=32'h17770551; exactly 8 word transfers; 2 MIX cycles observed.
- Same key with initval=1 -> out_hash=32'hCD628161. Repeat with random in_valid gaps and random out_ready stalls -> same hash; out_hash stable while stalled.
- "abcdefghijkl" (12 bytes), initval=0 -> no MIX cycle, FINAL directly; result matches the C hashlittle model. With LOOKUP3_BSWAP_EN defined, big-endian packed words give the same hash.
- Assert res during LOAD of a 30-byte key -> all outputs 0 immediately. After release, a new len=0 start -> out_hash=32'hDEADBEEF.
